unified_memory_arbiter: RTL

Single shared word-addressed memory serving the core's instruction port and data port through one arbitrated access engine. It replaces the separate instruction/data memories on the board with one storage array, so instruction fetches and data stores are coherent. Data width, depth and access latency are parametrised, and each port uses a request/ack handshake.

---
 rtl/unified_memory_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/unified_memory_arbiter.sv
// Shared instruction/data word memory behind a single arbitrated access engine.
// Define UMEM_RR_ARB_EN to resolve I/D ties round-robin instead of data-port priority.
module unified_memory_arbiter #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] IAddr,
   input  logic                  IReadEnable,
   output logic                  IAck,
   output logic [WIDTH-1:0]      IData,
   input  logic [ADDR_WIDTH-1:0] DAddr,
   input  logic [WIDTH-1:0]      DWriteData,
   input  logic                  DReadEnable,
   input  logic                  DWriteEnable,
   input  logic [WIDTH/8-1:0]    DByteEnable,
   output logic                  DAck,
   output logic [WIDTH-1:0]      DReadData
);

   localparam int unsigned NB    = WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               port_q, port_d;   // 1 = instruction port
   logic               last_q, last_d;   // 1 = instruction port granted last
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]      be_q, be_d;
   logic               we_q, we_d;
   logic               iack_q, iack_d;
   logic               dack_q, dack_d;
   logic [WIDTH-1:0]   idata_q, idata_d;
   logic [WIDTH-1:0]   drdata_q, drdata_d;

   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic               i_req_c, d_req_c, grant_i_c;
   logic [IDX_W-1:0]   i_idx_c, d_idx_c, rd_idx_c;
   logic [WIDTH-1:0]   rd_word_c, wr_word_c;
   logic               enter_ack_c, ack_i_c, mem_we_c;
   logic               unused_c;

   assign i_req_c = IReadEnable;
   assign d_req_c = DReadEnable | DWriteEnable;
   assign i_idx_c = IAddr[OFF_W +: IDX_W];
   assign d_idx_c = DAddr[OFF_W +: IDX_W];
   assign unused_c = ^{IAddr, DAddr, last_q};

`ifdef UMEM_RR_ARB_EN
   assign grant_i_c = i_req_c & (~d_req_c | ~last_q);
`else
   assign grant_i_c = i_req_c & ~d_req_c;
`endif

   // Read happens on entry to ACK so a read-modify-write returns the pre-write word.
   assign rd_idx_c  = (state_q == S_IDLE) ? (grant_i_c ? i_idx_c : d_idx_c) : idx_q;
   assign rd_word_c = mem_q[rd_idx_c];

   always_comb begin
      wr_word_c = mem_q[idx_q];
      for (int b = 0; b < int'(NB); b++) begin
         if (be_q[b]) wr_word_c[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      port_d      = port_q;
      last_d      = last_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      we_d        = we_q;
      iack_d      = 1'b0;
      dack_d      = 1'b0;
      idata_d     = idata_q;
      drdata_d    = drdata_q;
      enter_ack_c = 1'b0;
      ack_i_c     = port_q;
      mem_we_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_req_c || d_req_c) begin
               port_d  = grant_i_c;
               last_d  = grant_i_c;
               idx_d   = grant_i_c ? i_idx_c : d_idx_c;
               wdata_d = DWriteData;
               be_d    = DByteEnable;
               we_d    = ~grant_i_c & DWriteEnable;
               cnt_d   = CNT_W'(LATENCY - 1);
               ack_i_c = grant_i_c;
               if (LATENCY == 1) enter_ack_c = 1'b1;
               else              state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(1)) enter_ack_c = 1'b1;
            else                    cnt_d       = cnt_q - CNT_W'(1);
         end
         S_ACK: begin
            mem_we_c = we_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_ack_c) begin
         state_d = S_ACK;
         if (ack_i_c) begin
            iack_d  = 1'b1;
            idata_d = rd_word_c;
         end else begin
            dack_d   = 1'b1;
            drdata_d = rd_word_c;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         port_q   <= 1'b0;
         last_q   <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         iack_q   <= 1'b0;
         dack_q   <= 1'b0;
         idata_q  <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         port_q   <= port_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         we_q     <= we_d;
         iack_q   <= iack_d;
         dack_q   <= dack_d;
         idata_q  <= idata_d;
         drdata_q <= drdata_d;
      end
   end

   // Storage is never cleared; a write in ACK is dropped if reset lands that cycle.
   always_ff @(posedge CLK) begin
      if (!RST && mem_we_c) mem_q[idx_q] <= wr_word_c;
   end

   assign IAck      = iack_q;
   assign DAck      = dack_q;
   assign IData     = idata_q;
   assign DReadData = drdata_q;

endmodule
